// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
// -----------------
// Feeds the FIR multiply-accumulate stage. The block holds the coefficient
// register file and a circular history buffer of input samples. Each accepted
// sample starts a pass that presents NUM_TAPS (sample, coefficient) pairs, one
// per cycle. The sequencer then waits for the MAC's done before it takes the
// next sample.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   reset_i        synchronous active-high reset
//   coef_we_i      coefficient write strobe
//   coef_addr_i    coefficient index k
//   coef_wdata_i   coefficient value h[k]
//   coef_err_o     one-cycle pulse after a rejected coefficient write
//   s_valid_i      input sample valid
//   s_ready_o      sequencer can accept a sample (IDLE and not in reset)
//   s_data_i       input sample
//   x_o            sample operand to the MAC
//   tap_o          coefficient operand to the MAC
//   mac_valid_o    x_o/tap_o pair valid this cycle
//   mac_first_o    pair is k=0; the MAC clears its accumulator
//   mac_last_o     pair is k=NUM_TAPS-1
//   mac_done_i     MAC result complete
//   busy_o         sequencer is not IDLE
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 11,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              coef_we_i,
  input  logic [ADDR_W-1:0] coef_addr_i,
  input  logic [DATA_W-1:0] coef_wdata_i,
  output logic              coef_err_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] tap_o,
  output logic              mac_valid_o,
  output logic              mac_first_o,
  output logic              mac_last_o,
  input  logic              mac_done_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hist_q [NUM_TAPS];
  logic [DATA_W-1:0] coef_q [NUM_TAPS];
  logic [DATA_W-1:0] x_q, tap_q;
  logic              mac_valid_q, mac_first_q, mac_last_q, coef_err_q;

  logic              accept;
  logic              coef_ok;

  assign s_ready_o   = (state_q == IDLE) && !reset_i;
  assign busy_o      = (state_q != IDLE);
  assign x_o         = x_q;
  assign tap_o       = tap_q;
  assign mac_valid_o = mac_valid_q;
  assign mac_first_o = mac_first_q;
  assign mac_last_o  = mac_last_q;
  assign coef_err_o  = coef_err_q;

  // Handshake, write qualification and pointer next-state. rd_ptr walks the
  // history backwards from the newest sample (base) while cnt counts taps; both
  // wrap inside 0..NUM_TAPS-1 so no out-of-range address is ever formed.
  always_comb begin
    accept   = s_valid_i && s_ready_o;
    coef_ok  = coef_we_i && (state_q == IDLE) && (coef_addr_i <= LAST_K);
    wptr_d   = wptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      wptr_d   = (wptr_q == LAST_K) ? '0 : wptr_q + 1'b1;
      rd_ptr_d = wptr_q;
      cnt_d    = '0;
    end else if ((state_q == ISSUE) && (cnt_q != LAST_K)) begin
      rd_ptr_d = (rd_ptr_q == '0) ? LAST_K : rd_ptr_q - 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Sequencer state, storage and registered MAC outputs. The k=0 pair is
  // registered on the accept edge itself, so the incoming sample and a
  // same-cycle write to coefficient 0 are forwarded rather than read back.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      tap_q       <= '0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      wptr_q     <= wptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      coef_err_q <= coef_we_i && !coef_ok;
      if (coef_ok) begin
        coef_q[coef_addr_i] <= coef_wdata_i;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            hist_q[wptr_q] <= s_data_i;
            state_q        <= ISSUE;
            x_q            <= s_data_i;
            tap_q          <= (coef_ok && (coef_addr_i == '0)) ? coef_wdata_i : coef_q[0];
            mac_valid_q    <= 1'b1;
            mac_first_q    <= 1'b1;
            mac_last_q     <= (LAST_K == '0);
          end
        end
        ISSUE: begin
          if (cnt_q == LAST_K) begin
            state_q     <= WAIT;
            x_q         <= '0;
            tap_q       <= '0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
          end else begin
            x_q         <= hist_q[rd_ptr_d];
            tap_q       <= coef_q[cnt_d];
            mac_first_q <= 1'b0;
            mac_last_q  <= (cnt_d == LAST_K);
          end
        end
        WAIT: begin
          if (mac_done_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer
// Self-checking bench for fir_tap_sequencer. A small reference model of the
// history buffer and coefficient file predicts every (X, tap) pair of a pass;
// predictions are queued when a sample is pushed and popped by a monitor each
// cycle the DUT shows mac_valid. Hand-derived constants cross-check the model.
module tb_fir_tap_sequencer;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [31:0] coef_wdata;
  logic        coef_err;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] x;
  logic [31:0] tap;
  logic        mac_valid;
  logic        mac_first;
  logic        mac_last;
  logic        mac_done;
  logic        busy;

  fir_tap_sequencer #(.NUM_TAPS(N), .DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata),
    .coef_err_o(coef_err),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .x_o(x), .tap_o(tap), .mac_valid_o(mac_valid),
    .mac_first_o(mac_first), .mac_last_o(mac_last),
    .mac_done_i(mac_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] tap;
    logic        first;
    logic        last;
  } pair_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        expErr;
  } coefVec_t;

  typedef struct {
    logic [31:0] sample;
    logic [31:0] expX0;
    logic [31:0] expX1;
    logic [31:0] expX2;
    int          doneDelay;
    bit          earlyDone;
    bit          busyWrite;
  } passVec_t;

  pair_t       expQ[$];
  logic [31:0] mHist [N];
  logic [31:0] mCoef [N];
  int          mWptr;
  logic [31:0] capX   [16];
  logic [31:0] capTap [16];
  int          capIdx;
  int          checks = 0;
  int          errors = 0;

  coefVec_t coefTab [13];
  passVec_t passTab [3];

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mHist[i] = '0;
      mCoef[i] = '0;
    end
    mWptr = 0;
  endfunction

  // Monitor: every valid pair must match the next prediction.
  always @(negedge clk) begin
    if (mac_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPair", 64'd1, 64'd0);
      end else begin
        pair_t e;
        e = expQ.pop_front();
        checkOutput("pairX", 64'(x), 64'(e.x));
        checkOutput("pairTap", 64'(tap), 64'(e.tap));
        checkOutput("pairFlags", 64'({mac_first, mac_last}), 64'({e.first, e.last}));
        if (capIdx < 16) begin
          capX[capIdx]   = x;
          capTap[capIdx] = tap;
          capIdx++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h55;
    expQ.delete();
    tick();
    tick();
    checkOutput("rstReady", 64'(s_ready), 64'd0);
    checkOutput("rstValid", 64'(mac_valid), 64'd0);
    checkOutput("rstFlags", 64'({mac_first, mac_last}), 64'd0);
    checkOutput("rstX", 64'(x), 64'd0);
    checkOutput("rstTap", 64'(tap), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstErr", 64'(coef_err), 64'd0);
    reset   = 1'b0;
    s_valid = 1'b0;
    modelReset();
    tick();
    checkOutput("noAcceptInReset", 64'(busy), 64'd0);
  endtask

  task automatic applyCoefWrite(input logic [3:0] addr, input logic [31:0] data,
                                input logic expErr);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = data;
    tick();
    coef_we = 1'b0;
    checkOutput("coefErr", 64'(coef_err), 64'(expErr));
    if (expErr) begin
      tick();
      checkOutput("coefErrPulse", 64'(coef_err), 64'd0);
    end else begin
      mCoef[addr] = data;
    end
  endtask

  task automatic loadCoefs();
    for (int i = 0; i < N; i++) begin
      applyCoefWrite(coefTab[i].addr, coefTab[i].data, coefTab[i].expErr);
    end
  endtask

  // One sample pass with optional corner-case hooks.
  task automatic applyStimulus(input logic [31:0] v, input int doneDelay,
                               input bit earlyDone, input bit busyWrite,
                               input int abortAt, input bit coWrite,
                               input logic [3:0] coAddr, input logic [31:0] coData);
    int guard;
    int base;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("readyBeforePush", 64'(s_ready), 64'd1);
    capIdx  = 0;
    s_valid = 1'b1;
    s_data  = v;
    if (coWrite) begin
      coef_we    = 1'b1;
      coef_addr  = coAddr;
      coef_wdata = coData;
      if (int'(coAddr) < N) mCoef[coAddr] = coData;
    end
    mHist[mWptr] = v;
    base  = mWptr;
    mWptr = (mWptr + 1) % N;
    for (int k = 0; k < N; k++) begin
      pair_t p;
      p.x     = mHist[(base - k + N) % N];
      p.tap   = mCoef[k];
      p.first = (k == 0);
      p.last  = (k == N - 1);
      expQ.push_back(p);
    end
    tick();
    s_valid = 1'b0;
    coef_we = 1'b0;
    checkOutput("issueLatency", 64'(mac_valid), 64'd1);
    for (int k = 0; k < N; k++) begin
      checkOutput("readyLowIssue", 64'(s_ready), 64'd0);
      if (abortAt == k) begin
        reset = 1'b1;
        expQ.delete();
        modelReset();
        tick();
        checkOutput("abortValid", 64'(mac_valid), 64'd0);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        return;
      end
      mac_done = earlyDone && (k == 2);
      if (busyWrite && k == 3) begin
        coef_we    = 1'b1;
        coef_addr  = 4'd3;
        coef_wdata = 32'hDEAD_BEEF;
      end
      tick();
      mac_done = 1'b0;
      if (busyWrite && k == 3) begin
        coef_we = 1'b0;
        checkOutput("busyWriteErr", 64'(coef_err), 64'd1);
      end
      if (busyWrite && k == 4) checkOutput("busyErrPulse", 64'(coef_err), 64'd0);
    end
    checkOutput("waitValid", 64'(mac_valid), 64'd0);
    checkOutput("waitBusy", 64'(busy), 64'd1);
    checkOutput("scoreboardDrain", 64'(expQ.size()), 64'd0);
    for (int d = 0; d < doneDelay; d++) begin
      tick();
      checkOutput("waitHold", 64'(busy), 64'd1);
      checkOutput("readyLowWait", 64'(s_ready), 64'd0);
    end
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    checkOutput("readyAfterDone", 64'(s_ready), 64'd1);
    checkOutput("idleAfterDone", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) coefTab[k] = '{4'(k), 32'(k + 1), 1'b0};
    coefTab[11] = '{4'd12, 32'd99, 1'b1};
    coefTab[12] = '{4'd15, 32'd77, 1'b1};
    passTab[0] = '{32'd5, 32'd5, 32'd0, 32'd0, 0, 1'b0, 1'b0};
    passTab[1] = '{32'd7, 32'd7, 32'd5, 32'd0, 0, 1'b0, 1'b1};
    passTab[2] = '{32'd9, 32'd9, 32'd7, 32'd5, 3, 1'b1, 1'b0};

    reset = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    s_valid = 1'b0; s_data = '0; mac_done = 1'b0; capIdx = 0;
    modelReset();

    // Reset values, full coefficient load, out-of-range writes in IDLE.
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyCoefWrite(coefTab[i].addr, coefTab[i].data, coefTab[i].expErr);
    end

    // Single sample: X = 1,0,...; tap = 1..11; done two cycles into WAIT.
    applyStimulus(32'd1, 2, 1'b0, 1'b0, -1, 1'b0, 4'd0, 32'd0);
    checkOutput("singleX0", 64'(capX[0]), 64'd1);
    checkOutput("singleX1", 64'(capX[1]), 64'd0);
    checkOutput("singleTap0", 64'(capTap[0]), 64'd1);
    checkOutput("singleTap10", 64'(capTap[10]), 64'd11);

    // History order, busy write rejection, early mac_done.
    doReset();
    loadCoefs();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(passTab[i].sample, passTab[i].doneDelay, passTab[i].earlyDone,
                    passTab[i].busyWrite, -1, 1'b0, 4'd0, 32'd0);
      checkOutput("histX0", 64'(capX[0]), 64'(passTab[i].expX0));
      checkOutput("histX1", 64'(capX[1]), 64'(passTab[i].expX1));
      checkOutput("histX2", 64'(capX[2]), 64'(passTab[i].expX2));
      checkOutput("oldTap3", 64'(capTap[3]), 64'd4);
    end

    // Coefficient write in the same cycle as the sample accept.
    applyStimulus(32'd11, 0, 1'b0, 1'b0, -1, 1'b1, 4'd0, 32'd100);
    checkOutput("sameCycleTap0", 64'(capTap[0]), 64'd100);
    checkOutput("sameCycleTap1", 64'(capTap[1]), 64'd2);

    // Wrap-around: 13 samples into an 11-deep history.
    doReset();
    loadCoefs();
    for (int s = 1; s <= 13; s++) begin
      applyStimulus(32'(s), 0, 1'b0, 1'b0, -1, 1'b0, 4'd0, 32'd0);
    end
    checkOutput("wrapX0", 64'(capX[0]), 64'd13);
    checkOutput("wrapX1", 64'(capX[1]), 64'd12);
    checkOutput("wrapX10", 64'(capX[10]), 64'd3);
    checkOutput("wrapWptr", 64'(dut.wptr_q), 64'd2);

    // Reset at k=4, then a fresh pass sees cleared history and coefficients.
    applyStimulus(32'd20, 0, 1'b0, 1'b0, 4, 1'b0, 4'd0, 32'd0);
    applyStimulus(32'd1, 0, 1'b0, 1'b0, -1, 1'b0, 4'd0, 32'd0);
    checkOutput("postAbortX0", 64'(capX[0]), 64'd1);
    checkOutput("postAbortX1", 64'(capX[1]), 64'd0);
    checkOutput("postAbortTap0", 64'(capTap[0]), 64'd0);
    checkOutput("postAbortTap5", 64'(capTap[5]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
